// File: rtl/dut_mon_pkg.sv
// Shared types and constants for the DUT output monitor and its UART transmitter.
package dut_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_FRAME_BITS  = 10;
  localparam int DEFAULT_BAUD_DIV = 104;

endpackage

// File: rtl/dut_mon_uart_tx_8n1.sv
// 8N1 UART transmitter: accepts a byte on valid&ready and shifts it out LSB first.
// state | meaning
// IDLE  | line high, ready for a byte
// START | start bit (low) for BAUD_DIV cycles
// DATA  | eight data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (high); last cycle may accept the next byte directly
module uart_tx_8n1
  import dut_mon_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     state, state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state <= state_next;
      if (valid && ready) shift_reg <= data;
      if (state == IDLE || state_next != state || baud_last) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA) bit_idx <= '0;
      else if (baud_last) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[bit_idx];
        if (baud_last && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        // Accepting here lets frames run back-to-back without an idle bit.
        if (baud_last) begin
          ready      = 1'b1;
          state_next = valid ? START : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/dut_out_monitor.sv
// Samples the DUT output bus on falling edges of the divided DUT clock and
// reports every change over UART via a small FIFO.
module dut_out_monitor
  import dut_mon_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int FIFO_AW  = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       clk_dut,
  input  logic [7:0] dut_out,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic             clk_dut_q;
  logic             first_flag;
  logic [7:0]       last_val;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             fall, push_req, push, pop;
  logic             utx_ready, utx_busy;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign fall     = clk_dut_q && !clk_dut;
  assign push_req = fall && (first_flag || (dut_out != last_val));
  assign pop      = !fifo_empty && utx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!fifo_full || pop);

  always_ff @(posedge CLK) begin
    if (rst) begin
      clk_dut_q  <= 1'b0;
      first_flag <= 1'b1;
      last_val   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      clk_dut_q <= clk_dut;
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_val   <= dut_out;
        first_flag <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push) overflow <= 1'b1;
      tx_busy <= utx_busy || !fifo_empty;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= dut_out;
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .CLK   (CLK),
    .rst   (rst),
    .valid (!fifo_empty),
    .data  (mem[rd_ptr[FIFO_AW-1:0]]),
    .ready (utx_ready),
    .tx    (uart_tx),
    .busy  (utx_busy)
  );

endmodule

// File: tb/tb_dut_out_monitor.sv
// Self-checking bench: expected bytes are queued when a change is driven and
// compared by a UART receiver model when each frame completes.
module tb_dut_out_monitor;

  localparam int BD  = 4;
  localparam int AW  = 2;
  localparam int MID = BD / 2;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       clk_dut = 1'b0;
  logic [7:0] dut_out = 8'h00;
  logic       uart_tx, tx_busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rx_cnt   = 0;
  int rx_count = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] exp_q[$];
  int starts_q[$];

  dut_out_monitor #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .clk_dut  (clk_dut),
    .dut_out  (dut_out),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // UART receiver model, sampling mid-bit on the falling CLK edge.
  always @(negedge CLK) begin
    int j;
    logic done;
    done = 1'b0;
    if (rst) begin
      rx_cnt = 0;
    end else if (rx_cnt == 0) begin
      if (uart_tx === 1'b0) begin
        rx_cnt = 1;
        starts_q.push_back(cyc);
      end
    end else begin
      if (rx_cnt >= MID && (rx_cnt - MID) % BD == 0) begin
        j = (rx_cnt - MID) / BD;
        if (j == 0) check("rx_start_bit", {31'd0, uart_tx}, 32'd0);
        else if (j <= 8) rx_byte[j-1] = uart_tx;
        else begin
          check("rx_stop_bit", {31'd0, uart_tx}, 32'd1);
          check("rx_byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          rx_count++;
          rx_cnt = 0;
          done = 1'b1;
        end
      end
      if (!done) rx_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic dut_cycle(input logic [7:0] val, input int hi, input int lo);
    dut_out = val;
    clk_dut = 1'b1;
    step(hi);
    clk_dut = 1'b0;
    step(lo);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    step(4);
    while ((tx_busy || rx_cnt != 0) && n < 2000) begin
      step(1);
      n++;
    end
    check({tag, "_idle_timeout"}, {31'd0, n < 2000}, 32'd1);
    step(4);
  endtask

  initial begin
    int base;
    logic [7:0] v;
    logic [7:0] a5;
    logic exp_bit;

    step(3);
    rst = 1'b0;
    @(negedge CLK);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // 1: constant 0x00 -> one frame forced by first_flag only
    exp_q.push_back(8'h00);
    for (int i = 0; i < 6; i++) dut_cycle(8'h00, 8, 8);
    wait_idle("t1");
    check("t1_frames", rx_count, 32'd1);

    // 2: exact frame timing for 0xA5
    a5 = 8'hA5;
    exp_q.push_back(a5);
    dut_out = a5;
    clk_dut = 1'b1;
    step(2);
    clk_dut = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("t2_n1_idle", {31'd0, uart_tx}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k < 4) exp_bit = 1'b0;
      else if (k < 36) exp_bit = a5[(k-4)/4];
      else exp_bit = 1'b1;
      check($sformatf("t2_bit_k%0d", k), {31'd0, uart_tx}, {31'd0, exp_bit});
      if (k == 20) check("t2_busy_mid", {31'd0, tx_busy}, 32'd1);
    end
    wait_idle("t2");
    check("t2_frames", rx_count, 32'd2);

    // 3: fast changes produce back-to-back frames
    starts_q.delete();
    for (int i = 1; i <= 3; i++) begin
      v = 8'(i);
      exp_q.push_back(v);
      dut_cycle(v, 1, 1);
    end
    wait_idle("t3");
    check("t3_frames", starts_q.size(), 32'd3);
    if (starts_q.size() == 3) begin
      check("t3_gap_1", starts_q[1] - starts_q[0], 32'(10 * BD));
      check("t3_gap_2", starts_q[2] - starts_q[1], 32'(10 * BD));
    end
    check("t3_overflow", {31'd0, overflow}, 32'd0);

    // 4: six changes into a 4-deep FIFO -> sixth dropped, overflow sticky
    base = rx_count;
    for (int i = 0; i < 6; i++) begin
      v = 8'h10 + 8'(i);
      if (i < 5) exp_q.push_back(v);
      dut_cycle(v, 1, 1);
    end
    check("t4_overflow_set", {31'd0, overflow}, 32'd1);
    wait_idle("t4");
    check("t4_frames", rx_count - base, 32'd5);
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
    exp_q.push_back(8'h15);
    dut_cycle(8'h15, 2, 2);
    wait_idle("t4_retry");
    check("t4_retry_frames", rx_count - base, 32'd6);

    // 5: reset during DATA bit 3 aborts the frame
    dut_cycle(8'h5A, 2, 1);
    step(18);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge CLK);
    check("t5_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("t5_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    step(2);
    check("t5_line_held", {31'd0, uart_tx}, 32'd1);
    base = rx_count;
    exp_q.push_back(8'h00);
    dut_cycle(8'h00, 2, 2);
    wait_idle("t5");
    check("t5_fresh_frame", rx_count - base, 32'd1);

    // 6: glitch while clk_dut high, reverted before the fall -> nothing sent
    base = rx_count;
    starts_q.delete();
    dut_out = 8'h77;
    clk_dut = 1'b1;
    step(3);
    dut_out = 8'h00;
    step(1);
    clk_dut = 1'b0;
    step(4);
    check("t6_no_busy", {31'd0, tx_busy}, 32'd0);
    wait_idle("t6");
    check("t6_no_frame", starts_q.size(), 32'd0);
    check("t6_rx_count", rx_count - base, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_out_monitor.md
Name: dut_out_monitor

Overview:
- Observes the 8-bit output bus of the TinyTapeout DUT and reports every change of that bus to the host over a UART transmit line.
- Lives in the FPGA top level next to the clock divider and reset-delay logic, which drive the DUT's inputs.
- Samples at the falling edge of the divided DUT clock, so DUT outputs have had half a DUT period to settle.
- Changed values are queued in a small FIFO and serialised as 8N1 bytes.

Parameters:
- BAUD_DIV, 104: CLK cycles per UART bit (12 MHz / 115200). Legal range 2..65535.
- FIFO_AW, 4: FIFO address width. Depth = 2^FIFO_AW entries.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- clk_dut  input  1  divided DUT clock, a registered level in the CLK domain.
- dut_out  input  8  DUT output bus, CLK-domain signal.
- uart_tx  output  1  serial output, idle high.
- tx_busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
- overflow  output  1  sticky: a changed sample was dropped because the FIFO was full.

Behaviour:
- Reset values (rst sampled high at a CLK edge):
  - uart_tx=1, tx_busy=0, overflow=0.
  - FIFO emptied; TX FSM in IDLE; baud and bit counters cleared.
  - first_flag=1; last_val=0; clk_dut_q=0.
- Reset mid-frame aborts the frame. uart_tx is 1 from the next edge on; no partial byte is resumed.
- Edge detect: clk_dut_q registers clk_dut every cycle. A sample event (fall) is the cycle where clk_dut_q=1 and clk_dut=0. A rising edge of clk_dut does nothing.
- Change detect, in the fall cycle:
  - The push request is true if first_flag=1 or dut_out != last_val.
  - If the FIFO is not full, or a pop occurs in the same cycle, then at that edge: write dut_out, set last_val=dut_out, clear first_flag.
  - If the FIFO is full and no pop occurs: drop the sample, set overflow=1, leave last_val unchanged. The next fall with a different value retries.
  - overflow clears only on rst.
- FIFO:
  - Circular buffer with write/read pointers of FIFO_AW+1 bits.
  - Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2^(FIFO_AW+1).
  - Simultaneous push and pop is legal at any occupancy, including full and empty with write-first bypass not required. An empty FIFO pops nothing that cycle.
- TX FSM states and timing:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into shift_reg and go to START.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA with bit_idx=0.
  - DATA: uart_tx=shift_reg[bit_idx], LSB first, each bit BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE. The FIFO is re-checked in the same cycle, giving back-to-back frames with no extra idle bit.
- Latency:
  - Fall cycle N: push.
  - N+1: FIFO non-empty; IDLE pops.
  - N+2: uart_tx low (START begins).
  - Frame length is exactly 10*BAUD_DIV cycles.
- Baud counter: counts 0..BAUD_DIV-1, resets on every state change. Width is $clog2(BAUD_DIV).
- tx_busy = (state != IDLE) | !fifo_empty, registered.
- Falls arriving during a frame are handled independently through the FIFO.

Decomposition:
- Package dut_mon_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - UART_FRAME_BITS=10.
  - Default BAUD_DIV constant.
- One sub-module, uart_tx_8n1. It contains the FSM plus baud/bit counters and exposes:
  - inputs: valid, data[7:0].
  - outputs: ready, tx, busy.
- The FIFO and change detector are coded inline in dut_out_monitor.

Test Plan:
1. Reset, then clk_dut toggling every 8 cycles with dut_out=0x00 → exactly one frame 0x00, because first_flag forces it; further falls produce no frames.
2. BAUD_DIV=4: dut_out=0xA5 before a fall in cycle N → uart_tx=0 at N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, 40 cycles total.
3. dut_out changing 0x01→0x02→0x03 on consecutive falls faster than the frame rate → frames 0x01,0x02,0x03 back-to-back with no gap between stop and next start; overflow stays 0.
4. FIFO_AW=2, BAUD_DIV=100: 6 distinct values on consecutive falls → first value popped and 4 queued, 6th dropped; overflow=1 and stays 1; host receives 5 bytes.
5. rst asserted for one cycle during DATA bit 3 → uart_tx=1 from the next cycle, tx_busy=0, overflow=0; next fall with any value emits a fresh frame.
6. dut_out changes only while clk_dut is high and reverts before the fall → no frame emitted.
